alu_divider: RTL

- Multi-cycle 32-bit integer divider that supplies the inverse of the ALU's multiply and shift operations.
- Sits beside the combinational ALU in the CPU execute stage and uses the same operand, op and flag conventions (a, b, op, c, is_zero, is_negative).
- The CPU issues a start pulse, stalls while busy is high, and captures c and the flags on done.
- Computes unsigned or signed quotient or remainder with a radix-2 restoring algorithm, one quotient bit per cycle.

---
 rtl/alu_pkg.sv | 10 +
 rtl/alu_divider_div_step.sv | 19 +
 rtl/alu_divider.sv | 122 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU/divider op codes, divider state encoding and datapath width
package alu_pkg;
    localparam int WIDTH  = 32;
    localparam int CYCLES = WIDTH + 3;
    localparam logic [4:0] OP_DIVU = 5'd20;
    localparam logic [4:0] OP_REMU = 5'd21;
    localparam logic [4:0] OP_DIV  = 5'd22;
    localparam logic [4:0] OP_REM  = 5'd23;
    typedef enum logic [1:0] {IDLE, SETUP, DIVIDE, FIXUP} div_state_t;
endpackage

// File: rtl/alu_divider_div_step.sv
// div_step: one radix-2 restoring division step on the {rem, quo} pair
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] quo_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] quo_o
);
    logic [W:0] shifted;
    logic [W:0] trial;
    always_comb begin
        shifted = {rem_i, quo_i[W-1]};
        trial   = shifted - {1'b0, divisor_i};
        rem_o   = trial[W] ? shifted[W-1:0] : trial[W-1:0];
        quo_o   = {quo_i[W-2:0], ~trial[W]};
    end
endmodule

// File: rtl/alu_divider.sv
// alu_divider: multi-cycle signed/unsigned 32-bit divider with fixed start-to-done latency
module alu_divider
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [7:0]        op,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  c,
    output logic              is_zero,
    output logic              is_negative
);
    div_state_t state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, dvs_q, dvs_d, rem_q, rem_d, quo_q, quo_d, c_q, c_d;
    logic [4:0] op_q, op_d, cnt_q, cnt_d;
    logic sq_q, sq_d, sr_q, sr_d, z_q, z_d, n_q, n_d, done_q, done_d;
    logic [WIDTH-1:0] step_rem, step_quo, q_fix, r_fix, res;
    logic signed_op, div0, unused_op;
    assign unused_op = ^op[7:5];
    div_step #(.W(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );
    // Divide by zero keeps the raw unsigned result: all-ones quotient, untouched dividend
    always_comb begin
        signed_op = (op_q == OP_DIV) || (op_q == OP_REM);
        div0      = (b_q == '0);
        q_fix     = (sq_q && !div0) ? -quo_q : quo_q;
        r_fix     = div0 ? a_q : sr_q ? -rem_q : rem_q;
        res       = (op_q == OP_DIVU || op_q == OP_DIV) ? q_fix :
                    (op_q == OP_REMU || op_q == OP_REM) ? r_fix : '0;
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        c_d     = c_q;
        z_d     = z_q;
        n_d     = n_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                a_d     = a;
                b_d     = b;
                op_d    = op[4:0];
                state_d = SETUP;
            end
            SETUP: begin
                sq_d    = signed_op & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                sr_d    = signed_op & a_q[WIDTH-1];
                dvs_d   = (signed_op && b_q[WIDTH-1]) ? -b_q : b_q;
                quo_d   = (signed_op && a_q[WIDTH-1]) ? -a_q : a_q;
                rem_d   = '0;
                cnt_d   = 5'(WIDTH - 1);
                state_d = DIVIDE;
            end
            DIVIDE: begin
                rem_d   = step_rem;
                quo_d   = step_quo;
                cnt_d   = cnt_q - 5'd1;
                state_d = (cnt_q == 5'd0) ? FIXUP : DIVIDE;
            end
            FIXUP: begin
                c_d     = res;
                z_d     = (res == '0);
                n_d     = res[WIDTH-1];
                done_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            c_q     <= '0;
            z_q     <= 1'b1;
            n_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            c_q     <= c_d;
            z_q     <= z_d;
            n_q     <= n_d;
            done_q  <= done_d;
        end
    end
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign c           = c_q;
    assign is_zero     = z_q;
    assign is_negative = n_q;
endmodule
